// File: rtl/apb_global_pkg.sv
// Shared APB constants and the completer FSM state type.
package apb_global_pkg;
   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH    = 32;
   localparam int STRB_WIDTH    = DATA_WIDTH / 8;
   localparam int MEM_DEPTH     = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slave_state_e;
endpackage

// File: rtl/apb_if.sv
// APB4 signal bundle with initiator (master) and completer (slave) views.
interface apb_if #(
   parameter int ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = apb_global_pkg::DATA_WIDTH
);
   logic                      psel;
   logic                      penable;
   logic [ADDRESS_WIDTH-1:0]  paddr;
   logic                      pwrite;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [2:0]                pprot;
   logic                      pready;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pslverr;

   modport master (output psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
                   input  pready, prdata, pslverr);
   modport slave  (input  psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
                   output pready, prdata, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// Word array with byte-strobed synchronous write and registered read.
// rdata is zero in any cycle that follows an edge where re was low.
module apb_slave_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [$clog2(MEM_DEPTH)-1:0]  waddr,
   input  logic [DATA_WIDTH/8-1:0]       wstrb,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          re,
   input  logic [$clog2(MEM_DEPTH)-1:0]  raddr,
   output logic [DATA_WIDTH-1:0]         rdata
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
      else         rdata <= '0;
   end
endmodule

// File: rtl/apb_slave_responder.sv
// APB4 completer over a word register array with programmable wait states.
// Optional APB_SLAVE_PPROT_CHECK_EN: non-secure accesses to the upper half error out.
module apb_slave_responder #(
   parameter int                       ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
   parameter int                       DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
   parameter int                       MEM_DEPTH     = apb_global_pkg::MEM_DEPTH,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
   input  logic       pclk,
   input  logic       preset,
   apb_if.slave       bus,
   input  logic [3:0] wait_cycles
);
   import apb_global_pkg::*;

   localparam int STRB_W     = DATA_WIDTH / 8;
   localparam int IDX_W      = $clog2(MEM_DEPTH);
   localparam int BYTE_SHIFT = $clog2(STRB_W);

   apb_slave_state_e         state_q, state_n;
   logic [3:0]               wcnt_q, wcnt_n;
   logic                     pready_q, pready_n;
   logic                     pslverr_q, pslverr_n;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic                     write_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [STRB_W-1:0]        strb_q;
   logic [2:0]               prot_q;
   logic                     latch, set_rdy, rd_en, wr_en;

   // In IDLE the decode looks at the live bus so a zero-wait read can be served at the setup edge.
   logic [ADDRESS_WIDTH-1:0] dec_addr, dec_off;
   logic                     dec_write, dec_ok;
   logic [2:0]               dec_prot;
   logic [IDX_W-1:0]         dec_idx;
   logic                     unused_prot;

   always_comb begin
      dec_addr  = (state_q == IDLE) ? bus.paddr  : addr_q;
      dec_write = (state_q == IDLE) ? bus.pwrite : write_q;
      dec_prot  = (state_q == IDLE) ? bus.pprot  : prot_q;
      dec_off   = dec_addr - BASE_ADDR;
      dec_idx   = dec_off[BYTE_SHIFT +: IDX_W];
      dec_ok    = (dec_addr >= BASE_ADDR)
                  && (dec_off < ADDRESS_WIDTH'(MEM_DEPTH * STRB_W))
                  && ((dec_off & ADDRESS_WIDTH'(STRB_W - 1)) == '0);
`ifdef APB_SLAVE_PPROT_CHECK_EN
      if (dec_prot[1] && dec_idx[IDX_W-1]) dec_ok = 1'b0;
`endif
   end

   assign unused_prot = ^dec_prot;

   always_comb begin
      state_n   = state_q;
      wcnt_n    = wcnt_q;
      pready_n  = 1'b0;
      pslverr_n = 1'b0;
      latch     = 1'b0;
      set_rdy   = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.psel && !bus.penable) begin
               latch   = 1'b1;
               state_n = ACCESS;
               wcnt_n  = wait_cycles;
               set_rdy = (wait_cycles == 4'd0);
            end
         end
         ACCESS: begin
            if (!(bus.psel && bus.penable)) begin
               state_n = IDLE;
            end else if (pready_q) begin
               state_n = IDLE;
               wr_en   = write_q && dec_ok;
            end else if (wcnt_q > 4'd1) begin
               wcnt_n = wcnt_q - 4'd1;
            end else begin
               wcnt_n  = 4'd0;
               set_rdy = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (set_rdy) begin
         pready_n  = 1'b1;
         pslverr_n = !dec_ok;
      end
      rd_en = set_rdy && !dec_write && dec_ok;
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prot_q    <= '0;
      end else begin
         state_q   <= state_n;
         wcnt_q    <= wcnt_n;
         pready_q  <= pready_n;
         pslverr_q <= pslverr_n;
         if (latch) begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            strb_q  <= bus.pstrb;
            prot_q  <= bus.pprot;
         end
      end
   end

   apb_slave_regfile #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_regfile (
      .clk   (pclk),
      .rst   (preset),
      .we    (wr_en),
      .waddr (dec_idx),
      .wstrb (strb_q),
      .wdata (wdata_q),
      .re    (rd_en),
      .raddr (dec_idx),
      .rdata (bus.prdata)
   );

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed and random APB transfers against a word-array reference model.
module tb_apb_slave_responder;
   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0;

   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic [3:0] wait_cycles = 4'd0;

   apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_slave_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .pclk        (pclk),
      .preset      (preset),
      .bus         (bus),
      .wait_cycles (wait_cycles)
   );

   always #5 pclk = ~pclk;

   int          ncmp = 0;
   int          nfail = 0;
   logic [31:0] model [DEPTH];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a, input logic [2:0] prot);
      logic [31:0] off;
      if (a < BASE) return 1'b0;
      off = a - BASE;
      if (off >= DEPTH * 4) return 1'b0;
      if (off % 4 != 0) return 1'b0;
`ifdef APB_SLAVE_PPROT_CHECK_EN
      if (prot[1] && (off / 4) >= DEPTH / 2) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic idle();
      @(negedge pclk);
      bus.psel = 1'b0;
      bus.penable = 1'b0;
   endtask

   // One full transfer; returns right after pready is seen so the next setup can follow back-to-back.
   task automatic xfer(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input logic [3:0] wt);
      int          lat;
      int          idx;
      bit          quiet;
      bit          ok;
      logic [31:0] exp_rd;
      ok = addr_ok(a, p);
      idx = int'((a - BASE) / 4);
      exp_rd = (!w && ok) ? model[idx] : 32'h0;
      @(negedge pclk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w;
      bus.pwdata = d; bus.pstrb = s; bus.pprot = p; wait_cycles = wt;
      @(negedge pclk);
      bus.penable = 1'b1;
      wait_cycles = 4'($urandom);
      lat = 1;
      quiet = 1'b1;
      while (bus.pready !== 1'b1 && lat < 20) begin
         if (bus.prdata !== '0 || bus.pslverr !== 1'b0) quiet = 1'b0;
         @(negedge pclk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(wt) + 32'd1);
      chk({tag, " quiet-wait"}, 32'(quiet), 32'd1);
      chk({tag, " pslverr"}, 32'(bus.pslverr), 32'(!ok));
      if (!w) chk({tag, " prdata"}, bus.prdata, exp_rd);
      if (w && ok)
         for (int i = 0; i < 4; i++)
            if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
   endtask

   initial begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0;
      bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      repeat (2) @(negedge pclk);
      chk("reset pready", 32'(bus.pready), 32'd0);
      chk("reset prdata", bus.prdata, 32'h0);
      chk("reset pslverr", 32'(bus.pslverr), 32'd0);
      preset = 1'b0;

      xfer("rd0 after reset w3", 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 4'd3);
      xfer("wr deadbeef w0", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0);
      xfer("rd deadbeef w0", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 4'd0);
      xfer("wr word8 full", 1'b1, 32'h8, 32'h11223344, 4'hF, 3'b000, 4'd1);
      xfer("wr word8 strb0101", 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 3'b000, 4'd2);
      xfer("rd word8 merged", 1'b0, 32'h8, 32'h0, 4'hF, 3'b000, 4'd0);
      chk("merged model", model[2], 32'h11BB33DD);
      xfer("wr strb0 noop", 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 3'b000, 4'd0);
      xfer("rd after noop", 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 4'd1);
      xfer("rd out of range", 1'b0, BASE + 32'h40, 32'h0, 4'h0, 3'b000, 4'd2);
      xfer("rd misaligned", 1'b0, 32'h6, 32'h0, 4'h0, 3'b000, 4'd1);
      xfer("wr misaligned", 1'b1, 32'h5, 32'h12345678, 4'hF, 3'b000, 4'd0);
      xfer("rd word4 intact", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 4'd0);
      xfer("wr 55 prot010", 1'b1, 32'h20, 32'h55, 4'hF, 3'b010, 4'd1);
      xfer("wr 55 prot000", 1'b1, 32'h20, 32'h55, 4'hF, 3'b000, 4'd1);
      xfer("rd 55", 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0);
      idle();

      // Reset lands in the second access cycle of a long write.
      @(negedge pclk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0; bus.pwrite = 1'b1;
      bus.pwdata = 32'h1234; bus.pstrb = 4'hF; bus.pprot = 3'b000; wait_cycles = 4'd5;
      @(negedge pclk);
      bus.penable = 1'b1;
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      chk("midreset pready", 32'(bus.pready), 32'd0);
      chk("midreset prdata", bus.prdata, 32'h0);
      chk("midreset pslverr", 32'(bus.pslverr), 32'd0);
      preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      xfer("rd0 after midreset", 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 4'd2);
      xfer("rd8 after midreset", 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 4'd0);

      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
         else                          a = BASE + 32'($urandom_range(0, 'h50));
         xfer($sformatf("rand%0d", n), 1'($urandom), a, $urandom, 4'($urandom),
              3'($urandom), 4'($urandom_range(0, 4)));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      for (int i = 0; i < DEPTH; i++)
         xfer($sformatf("final rd%0d", i), 1'b0, BASE + 32'(i) * 4, 32'h0, 4'h0, 3'b000, 4'd0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
